// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory-ready handshake
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_load,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         WBSel,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOperation,
  output logic [1:0]         PCSrc,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEM_ADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEM_RD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEM_WB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEM_WR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_R_EXE   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_R_WB    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BEQ     = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_I_EXE   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_I_WB    = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JMP     = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_JAL     = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_JR      = STATE_W'(13);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic               r_alu_ok;
  logic [2:0]         r_alu_op;

  // State register; reset aborts any in-flight instruction back to FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  // R-type func decode shared by dispatch and the R_EXE ALU operation
  always_comb begin
    r_alu_ok = 1'b1;
    r_alu_op = ALU_ADD;
    case (func)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      default: r_alu_ok = 1'b0;
    endcase
  end

  // Next-state logic; waits in memory states until mem_ready
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (r_alu_ok)            next_state = S_R_EXE;
            else if (func == FN_JR)  next_state = S_JR;
            else                     next_state = S_FETCH;
          end
          OP_LW, OP_SW:     next_state = S_MEM_ADR;
          OP_BEQ:           next_state = S_BEQ;
          OP_ADDI, OP_SLTI: next_state = S_I_EXE;
          OP_J:             next_state = S_JMP;
          OP_JAL:           next_state = S_JAL;
          default:          next_state = S_FETCH;
        endcase
      end
      S_MEM_ADR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXE:   next_state = S_R_WB;
      S_I_EXE:   next_state = S_I_WB;
      default:   next_state = S_FETCH;
    endcase
  end

  // Moore output decode; held at zero while reset is asserted
  always_comb begin
    pc_load      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = 2'b00;
    WBSel        = 2'b00;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOperation = ALU_AND;
    PCSrc        = 2'b00;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite      = 1'b1;
            pc_load      = 1'b1;
            ALUSrcB      = 2'b01;
            ALUOperation = ALU_ADD;
          end
        end
        S_DECODE: begin
          ALUSrcB      = 2'b11;
          ALUOperation = ALU_ADD;
          case (opcode)
            OP_RTYPE: illegal = !(r_alu_ok || func == FN_JR);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J, OP_JAL: illegal = 1'b0;
            default:  illegal = 1'b1;
          endcase
        end
        S_MEM_ADR: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'b10;
          ALUOperation = ALU_ADD;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          WBSel      = 2'b01;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EXE: begin
          ALUSrcA      = 1'b1;
          ALUOperation = r_alu_op;
        end
        S_R_WB: begin
          RegWrite   = 1'b1;
          RegDst     = 2'b01;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA      = 1'b1;
          ALUOperation = ALU_SUB;
          PCSrc        = 2'b01;
          pc_load      = zero;
          instr_done   = 1'b1;
        end
        S_I_EXE: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'b10;
          ALUOperation = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_I_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_JMP: begin
          pc_load    = 1'b1;
          PCSrc      = 2'b10;
          instr_done = 1'b1;
        end
        // PC already holds PC+4 from FETCH, so it is the link value
        S_JAL: begin
          pc_load    = 1'b1;
          PCSrc      = 2'b10;
          RegWrite   = 1'b1;
          RegDst     = 2'b10;
          WBSel      = 2'b10;
          instr_done = 1'b1;
        end
        S_JR: begin
          pc_load    = 1'b1;
          PCSrc      = 2'b11;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic       zero, mem_ready;
  logic       pc_load, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, WBSel, ALUSrcB, PCSrc;
  logic       ALUSrcA, instr_done, illegal;
  logic [2:0] ALUOperation;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_load(pc_load), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .WBSel(WBSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOperation(ALUOperation),
    .PCSrc(PCSrc), .instr_done(instr_done), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  wire [19:0] act = {pc_load, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, WBSel,
                     ALUSrcA, ALUSrcB, ALUOperation, PCSrc, instr_done, illegal};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [19:0] o;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [19:0] eo(input logic pcl, iord, mr, mw, irw, rw,
                                     input logic [1:0] rd, wb, input logic asa,
                                     input logic [1:0] asb, input logic [2:0] aop,
                                     input logic [1:0] pcs, input logic done, ill);
    return {pcl, iord, mr, mw, irw, rw, rd, wb, asa, asb, aop, pcs, done, ill};
  endfunction

  task automatic v(input logic [5:0] op, fn, input logic z, mr,
                   input logic [3:0] st, input logic [19:0] o);
    vec_t e;
    e.op = op; e.fn = fn; e.z = z; e.mr = mr; e.st = st; e.o = o;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [19:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %05h want %05h", name, got, want);
    end
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BQ = 6'b000100;
  localparam logic [5:0] AI = 6'b001000, SI = 6'b001010, JJ = 6'b000010, JL = 6'b000011;
  localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FJR = 6'b001000;

  logic [19:0] fw, fr, dec, dec_ill, rexe_add, rexe_sub, rwb, madr, mrd, mwb;
  logic [19:0] mwr_w, mwr_r, beq1, beq0, iexe_add, iexe_slt, iwb, jmp, jal, jr;

  initial begin
    fw       = eo(0,0,1,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,0,0);
    fr       = eo(1,0,1,0,1,0,2'b00,2'b00,0,2'b01,3'b010,2'b00,0,0);
    dec      = eo(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b010,2'b00,0,0);
    dec_ill  = eo(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b010,2'b00,0,1);
    rexe_add = eo(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b010,2'b00,0,0);
    rexe_sub = eo(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b110,2'b00,0,0);
    rwb      = eo(0,0,0,0,0,1,2'b01,2'b00,0,2'b00,3'b000,2'b00,1,0);
    madr     = eo(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b010,2'b00,0,0);
    mrd      = eo(0,1,1,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,0,0);
    mwb      = eo(0,0,0,0,0,1,2'b00,2'b01,0,2'b00,3'b000,2'b00,1,0);
    mwr_w    = eo(0,1,0,1,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,0,0);
    mwr_r    = eo(0,1,0,1,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,1,0);
    beq1     = eo(1,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b110,2'b01,1,0);
    beq0     = eo(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b110,2'b01,1,0);
    iexe_add = eo(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b010,2'b00,0,0);
    iexe_slt = eo(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b111,2'b00,0,0);
    iwb      = eo(0,0,0,0,0,1,2'b00,2'b00,0,2'b00,3'b000,2'b00,1,0);
    jmp      = eo(1,0,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b10,1,0);
    jal      = eo(1,0,0,0,0,1,2'b10,2'b10,0,2'b00,3'b000,2'b10,1,0);
    jr       = eo(1,0,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b11,1,0);

    // add: 4 cycles, done only in R_WB
    v(R, FADD, 0, 1, 0, fr);   v(R, FADD, 0, 1, 1, dec);
    v(R, FADD, 0, 1, 6, rexe_add); v(R, FADD, 0, 1, 7, rwb);
    // sub
    v(R, FSUB, 1, 1, 0, fr);   v(R, FSUB, 1, 1, 1, dec);
    v(R, FSUB, 1, 1, 6, rexe_sub); v(R, FSUB, 1, 1, 7, rwb);
    // lw with two wait cycles in FETCH and MEM_RD; opcode garbage while waiting
    v(LW, 0, 0, 0, 0, fw);     v(LW, 0, 0, 0, 0, fw);      v(LW, 0, 0, 1, 0, fr);
    v(LW, 0, 0, 1, 1, dec);    v(LW, 0, 0, 1, 2, madr);
    v(6'h3f, 0, 0, 0, 3, mrd); v(SW, 0, 1, 0, 3, mrd);     v(LW, 0, 0, 1, 3, mrd);
    v(LW, 0, 0, 1, 4, mwb);
    // sw with one wait in MEM_WR
    v(SW, 0, 0, 1, 0, fr);     v(SW, 0, 0, 1, 1, dec);     v(SW, 0, 0, 1, 2, madr);
    v(SW, 0, 0, 0, 5, mwr_w);  v(SW, 0, 0, 1, 5, mwr_r);
    // beq taken, then not taken
    v(BQ, 0, 1, 1, 0, fr);     v(BQ, 0, 1, 1, 1, dec);     v(BQ, 0, 1, 1, 8, beq1);
    v(BQ, 0, 0, 1, 0, fr);     v(BQ, 0, 0, 1, 1, dec);     v(BQ, 0, 0, 1, 8, beq0);
    // addi, slti
    v(AI, 0, 0, 1, 0, fr);     v(AI, 0, 0, 1, 1, dec);
    v(AI, 0, 0, 1, 9, iexe_add); v(AI, 0, 0, 1, 10, iwb);
    v(SI, 0, 0, 1, 0, fr);     v(SI, 0, 0, 1, 1, dec);
    v(SI, 0, 0, 1, 9, iexe_slt); v(SI, 0, 0, 1, 10, iwb);
    // jumps
    v(JJ, 0, 0, 1, 0, fr);     v(JJ, 0, 0, 1, 1, dec);     v(JJ, 0, 0, 1, 11, jmp);
    v(JL, 0, 0, 1, 0, fr);     v(JL, 0, 0, 1, 1, dec);     v(JL, 0, 0, 1, 12, jal);
    v(R, FJR, 0, 1, 0, fr);    v(R, FJR, 0, 1, 1, dec);    v(R, FJR, 0, 1, 13, jr);
    // illegal opcode, then illegal R-type func; each returns straight to FETCH
    v(6'h3f, 0, 1, 1, 0, fr);  v(6'h3f, 0, 1, 1, 1, dec_ill);
    v(R, 6'h00, 1, 1, 0, fr);  v(R, 6'h00, 1, 1, 1, dec_ill);
    v(R, FADD, 0, 0, 0, fw);

    rst = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk("reset_outputs", act, 20'h0);
    chk("reset_state", {16'h0, state_dbg}, 20'h0);

    @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      opcode = tbl[i].op; func = tbl[i].fn; zero = tbl[i].z; mem_ready = tbl[i].mr;
      #1;
      chk($sformatf("vec%0d_state", i), {16'h0, state_dbg}, {16'h0, tbl[i].st});
      chk($sformatf("vec%0d_outputs", i), act, tbl[i].o);
    end

    // sw into MEM_WR wait, then asynchronous reset mid-wait
    @(negedge clk); opcode = SW; func = '0; zero = 1'b0; mem_ready = 1'b1; #1;
    chk("sw_fetch", act, fr);
    @(negedge clk); #1;
    chk("sw_decode", act, dec);
    @(negedge clk); #1;
    chk("sw_madr", act, madr);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("sw_wait_state", {16'h0, state_dbg}, 20'd5);
    chk("sw_wait_outputs", act, mwr_w);
    #1 rst = 1'b0; #1;
    chk("async_rst_outputs", act, 20'h0);
    chk("async_rst_state", {16'h0, state_dbg}, 20'h0);
    @(negedge clk); #1;
    chk("rst_held_outputs", act, 20'h0);
    @(negedge clk); rst = 1'b1; #1;
    chk("post_rst_state", {16'h0, state_dbg}, 20'h0);
    chk("post_rst_fetch", act, fw);
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("post_rst_fetch_ready", act, fr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle MIPS control unit: the producer side of the datapath control interface.
- Consumes opcode, func and ALU zero from a shared-memory multi-cycle datapath, and drives every mux select, write enable and ALU operation as a Moore FSM.
- Adds a memory-ready handshake so instruction and data accesses may take any number of cycles.
- Sits beside the multi-cycle datapath and replaces the single-cycle combinational controller.

Parameters:
- STATE_W, 4, width of the state register and of the state_dbg port.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26], valid from the IR after FETCH
- func  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read or write this cycle
- pc_load  out  1  PC write enable = PCWrite | (PCWriteCond & zero)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- RegWrite  out  1  register file write
- RegDst  out  2  write register: 00 = rt, 01 = rd, 10 = $31
- WBSel  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B input: 00 = register B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALUOperation  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- PCSrc  out  2  next PC: 00 = ALU, 01 = ALUOut, 10 = {PC[31:28], addr, 00}, 11 = register A
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  one-cycle pulse when the decoded opcode/func is unsupported
- state_dbg  out  STATE_W  current state

Behaviour:
- Reset
  - rst low asynchronously forces state to FETCH (0).
  - While rst is low, every output is 0 and state_dbg is 0.
  - Deasserting rst starts the FETCH request on the next cycle.
- Default output values: every output not listed for a state is 0. All outputs decode from state, except the mem_ready-qualified signals named below.
- States (encoding in parentheses):
  - FETCH (0): MemRead = 1, IorD = 0. Holds while mem_ready = 0. In the cycle mem_ready = 1: IRWrite = 1, pc_load = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOperation = add, PCSrc = 00; next state DECODE.
  - DECODE (1): ALUSrcA = 0, ALUSrcB = 11, add (branch target into ALUOut). Dispatch:
    - 000000 + func add/sub/and/or/slt (100000/100010/100100/100101/101010) -> R_EXE
    - 000000 + func 001000 -> JR
    - lw 100011 or sw 101011 -> MEM_ADR
    - beq 000100 -> BEQ
    - addi 001000 or slti 001010 -> I_EXE
    - j 000010 -> JMP
    - jal 000011 -> JAL
    - anything else: illegal = 1 for this cycle, then FETCH.
  - MEM_ADR (2): ALUSrcA = 1, ALUSrcB = 10, add. Next MEM_RD for lw, MEM_WR for sw.
  - MEM_RD (3): MemRead = 1, IorD = 1. Holds until mem_ready, then MEM_WB.
  - MEM_WB (4): RegWrite = 1, RegDst = 00, WBSel = 01, instr_done = 1. Next FETCH.
  - MEM_WR (5): MemWrite = 1, IorD = 1. Holds until mem_ready. instr_done = 1 in the mem_ready cycle, then FETCH.
  - R_EXE (6): ALUSrcA = 1, ALUSrcB = 00, ALUOperation from func. Next R_WB.
  - R_WB (7): RegWrite = 1, RegDst = 01, WBSel = 00, instr_done = 1. Next FETCH.
  - BEQ (8): ALUSrcA = 1, ALUSrcB = 00, sub, PCSrc = 01, pc_load = zero, instr_done = 1. Next FETCH.
  - I_EXE (9): ALUSrcA = 1, ALUSrcB = 10; add for addi, slt for slti. Next I_WB.
  - I_WB (10): RegWrite = 1, RegDst = 00, WBSel = 00, instr_done = 1. Next FETCH.
  - JMP (11): pc_load = 1, PCSrc = 10, instr_done = 1. Next FETCH.
  - JAL (12): pc_load = 1, PCSrc = 10, RegWrite = 1, RegDst = 10, WBSel = 10, instr_done = 1. Next FETCH. PC already holds PC+4.
  - JR (13): pc_load = 1, PCSrc = 11, instr_done = 1. Next FETCH.
  - Encodings 14 and 15: outputs 0, next FETCH.
- Opcode and func are sampled only in DECODE, R_EXE, I_EXE and MEM_ADR. Changes at other times are ignored.
- MemRead and MemWrite stay asserted for every wait cycle. Request signals never change while waiting.
- Latency with mem_ready tied to 1:
  - R-type, addi, slti, lw-less paths: R/I-type 4 cycles, sw 4, lw 5, beq 3, j/jal/jr 3.
  - Each mem_ready = 0 cycle adds one cycle.
- Reset asserted mid-instruction aborts it immediately; no write enable pulses after rst falls.

Test Plan:
- add (opcode 000000, func 100000), mem_ready = 1 -> states 0,1,6,7; R_EXE ALUOperation = 010; R_WB RegWrite = 1, RegDst = 01; instr_done in cycle 4 only.
- lw with mem_ready low for 2 cycles in both FETCH and MEM_RD -> FETCH held 3 cycles, MEM_RD held 3 cycles; IRWrite pulses once; MEM_WB WBSel = 01; total 9 cycles.
- beq with zero = 1, then zero = 0 -> pc_load = 1 with PCSrc = 01 in BEQ, then pc_load = 0 in BEQ; 3 cycles each.
- jal -> JAL state: RegDst = 10, WBSel = 10, RegWrite = 1, pc_load = 1, PCSrc = 10.
- opcode 111111, then R-type func 000000 -> illegal pulses one cycle in DECODE, returns to FETCH, and no RegWrite, MemWrite or pc_load beyond the FETCH increment.
- rst low during MEM_WR waiting -> MemWrite drops to 0 in the same cycle (async), state_dbg = 0; after release, FETCH asserts MemRead = 1.
